// File: rtl/wave_capture_if.sv
// Bus between the wave capture sequencer, the sample source, the wave
// display and the wave sample RAM write port.
interface wave_capture_if;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic [7:0]  write_sample;
    logic        write_enable;
    logic        read_index;

    // Environment side: supplies samples and idle, observes RAM writes.
    modport master (
        output new_sample_ready, new_sample_in, wave_display_idle,
        input  write_address, write_sample, write_enable, read_index
    );

    // Capture sequencer side.
    modport slave (
        input  new_sample_ready, new_sample_in, wave_display_idle,
        output write_address, write_sample, write_enable, read_index
    );
endinterface

// File: rtl/wave_capture_ctrl.sv
// Wave capture sequencer: arms on a positive-going zero crossing (or a
// forced timeout), writes 256 samples into the RAM half not on display,
// then flips the displayed half once the display reports idle.
module wave_capture_ctrl #(
    parameter int unsigned TIMEOUT_SAMPLES = 1024,
    parameter int unsigned TO_W            = 11
) (
    input  logic          clk,
    input  logic          reset,
    wave_capture_if.slave bus
);

    typedef enum logic [1:0] {
        S_ARMED  = 2'd0,
        S_ACTIVE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(TIMEOUT_SAMPLES);

    state_t          r_state;
    logic [7:0]      r_offset;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_prev_neg;
    logic            r_read_index;
    logic            r_write_enable;
    logic [8:0]      r_write_address;
    logic [7:0]      r_write_sample;

    state_t          w_state_nxt;
    logic [7:0]      w_offset_nxt;
    logic [TO_W-1:0] w_to_cnt_nxt;
    logic            w_prev_neg_nxt;
    logic            w_read_index_nxt;
    logic            w_write_enable_nxt;
    logic [8:0]      w_write_address_nxt;
    logic [7:0]      w_write_sample_nxt;

    logic            w_sample_neg;
    logic            w_crossing;
    logic [TO_W-1:0] w_to_cnt_inc;
    logic            w_timeout;
    logic [7:0]      w_sample_ob;
    logic            w_unused_low_bits;

    assign w_sample_neg  = bus.new_sample_in[15];
    assign w_crossing    = r_prev_neg && !w_sample_neg;
    assign w_to_cnt_inc  = r_to_cnt + TO_W'(1);
    assign w_timeout     = (TIMEOUT_SAMPLES != 0) && (w_to_cnt_inc == TIMEOUT_CNT);
    // Offset binary: flip the sign bit, keep the top 7 magnitude bits.
    assign w_sample_ob   = {~bus.new_sample_in[15], bus.new_sample_in[14:8]};
    // The low byte is below the display resolution and is dropped.
    assign w_unused_low_bits = ^bus.new_sample_in[7:0];

    // Next-state and next-output logic for the capture sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        w_state_nxt         = r_state;
        w_offset_nxt        = r_offset;
        w_to_cnt_nxt        = r_to_cnt;
        w_prev_neg_nxt      = bus.new_sample_ready ? w_sample_neg : r_prev_neg;
        w_read_index_nxt    = r_read_index;
        w_write_enable_nxt  = 1'b0;
        w_write_address_nxt = r_write_address;
        w_write_sample_nxt  = r_write_sample;

        unique case (r_state)
            S_ARMED: begin
                if (bus.new_sample_ready) begin
                    w_to_cnt_nxt = w_to_cnt_inc;
                    if (w_crossing || w_timeout) begin
                        w_write_enable_nxt  = 1'b1;
                        w_write_address_nxt = {~r_read_index, 8'd0};
                        w_write_sample_nxt  = w_sample_ob;
                        w_offset_nxt        = 8'd1;
                        w_state_nxt         = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                if (bus.new_sample_ready) begin
                    w_write_enable_nxt  = 1'b1;
                    w_write_address_nxt = {~r_read_index, r_offset};
                    w_write_sample_nxt  = w_sample_ob;
                    w_offset_nxt        = r_offset + 8'd1;
                    if (r_offset == 8'hFF) begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Samples arriving here only refresh the crossing history.
                if (bus.wave_display_idle) begin
                    w_read_index_nxt = ~r_read_index;
                    w_offset_nxt     = 8'd0;
                    w_to_cnt_nxt     = '0;
                    w_state_nxt      = S_ARMED;
                end
            end
            default: begin
                w_state_nxt = S_ARMED;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values.
        if (reset) begin
            r_state         <= S_ARMED;
            r_offset        <= 8'd0;
            r_to_cnt        <= '0;
            r_prev_neg      <= 1'b0;
            r_read_index    <= 1'b0;
            r_write_enable  <= 1'b0;
            r_write_address <= 9'd0;
            r_write_sample  <= 8'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_offset        <= w_offset_nxt;
            r_to_cnt        <= w_to_cnt_nxt;
            r_prev_neg      <= w_prev_neg_nxt;
            r_read_index    <= w_read_index_nxt;
            r_write_enable  <= w_write_enable_nxt;
            r_write_address <= w_write_address_nxt;
            r_write_sample  <= w_write_sample_nxt;
        end
    end

    assign bus.write_enable  = r_write_enable;
    assign bus.write_address = r_write_address;
    assign bus.write_sample  = r_write_sample;
    assign bus.read_index    = r_read_index;

endmodule
